// File: rtl/sub_serial_chunked.sv
// rtl/sub_serial_chunked.sv - multi-cycle WIDTH-bit subtractor, CHUNK bits per cycle with registered borrow
module sub_serial_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [KW-1:0]    k;
    logic             borrow;
    logic             sat_q;
    logic [WIDTH-1:0] a_q, b_q, acc;

    logic [CHUNK:0]       slice_res;
    logic [CHUNK-1:0]     d;
    logic                 bo;
    logic [WIDTH+CHUNK-1:0] acc_cat;
    logic [WIDTH-1:0]     raw;
    logic                 last;
    logic                 ovf_raw;

    // Operands shift right each slice, so the current slice is always the low chunk;
    // the result enters the accumulator from the top and is complete after NSLICE shifts.
    always_comb begin
        slice_res = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, borrow};
        d         = slice_res[CHUNK-1:0];
        bo        = slice_res[CHUNK];
        acc_cat   = {d, acc};
        raw       = acc_cat[WIDTH+CHUNK-1:CHUNK];
        last      = (k == LAST_K);
        // On the last slice the low chunks hold the original operand MSBs.
        ovf_raw   = (a_q[CHUNK-1] != b_q[CHUNK-1]) && (d[CHUNK-1] != a_q[CHUNK-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k          <= '0;
            borrow     <= 1'b0;
            sat_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            acc        <= '0;
            out_diff   <= '0;
            out_borrow <= 1'b0;
            out_ovf    <= 1'b0;
            out_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= in_a;
                        b_q    <= in_b;
                        sat_q  <= in_sat;
                        borrow <= in_bin;
                        k      <= '0;
                    end
                end
                BUSY: begin
                    a_q    <= a_q >> CHUNK;
                    b_q    <= b_q >> CHUNK;
                    acc    <= raw;
                    borrow <= bo;
                    k      <= k + 1'b1;
                    if (last) begin
                        out_borrow <= bo;
                        out_ovf    <= ovf_raw;
                        if (sat_q && bo) begin
                            out_diff <= '0;
                            out_zero <= 1'b1;
                        end else begin
                            out_diff <= raw;
                            out_zero <= (raw == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial_chunked.sv
// tb/tb_sub_serial_chunked.sv - directed scoreboard bench for sub_serial_chunked
module tb_sub_serial_chunked;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a, in_b;
    logic        in_bin, in_sat;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_diff;
    logic        out_borrow, out_ovf, out_zero;

    typedef struct packed {
        logic [15:0] diff;
        logic        borrow;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    sub_serial_chunked #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_bin    (in_bin),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .out_borrow(out_borrow),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic bin, input logic sat);
        exp_t        m;
        logic [16:0] r;
        r        = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        m.borrow = r[16];
        m.ovf    = (a[15] != b[15]) && (r[15] != a[15]);
        m.diff   = (sat && r[16]) ? 16'h0000 : r[15:0];
        m.zero   = (m.diff == 16'h0000);
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one operation, then wait for out_valid and compare against the scoreboard.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic bin, input logic sat);
        int   n;
        logic got;
        exp_t e;
        @(negedge clk);
        in_a = a; in_b = b; in_bin = bin; in_sat = sat; in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(model(a, b, bin, sat));
        #1;
        in_valid = 1'b0;
        in_a = 16'($urandom); in_b = 16'($urandom);
        in_bin = 1'($urandom); in_sat = 1'($urandom);
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) got = 1'b1;
        end
        check("latency", n, 4);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("diff",   out_diff,   e.diff);
            check("borrow", out_borrow, e.borrow);
            check("ovf",    out_ovf,    e.ovf);
            check("zero",   out_zero,   e.zero);
        end
    endtask

    task automatic finish_op();
        @(posedge clk); #1;
        check("valid_drop", out_valid, 0);
        check("ready_idle", in_ready, 1);
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_bin = 1'b0; in_sat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff",      out_diff,  0);
        check("rst_flags",     {out_borrow, out_ovf, out_zero}, 0);
        @(negedge clk); rst_n = 1'b1;

        run_op(16'h1234, 16'h0235, 1'b0, 1'b0); finish_op();
        run_op(16'h0000, 16'h0001, 1'b0, 1'b0); finish_op();
        run_op(16'h0000, 16'h0001, 1'b0, 1'b1); finish_op();
        run_op(16'h8000, 16'h0001, 1'b0, 1'b0); finish_op();
        run_op(16'h0005, 16'h0005, 1'b1, 1'b0); finish_op();
        run_op(16'h0005, 16'h0005, 1'b0, 1'b0); finish_op();

        // Consumer stall: result held, in_ready low, pending operand not taken.
        out_ready = 1'b0;
        run_op(16'hABCD, 16'h1234, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0001;
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1);
            check("stall_ready", in_ready, 0);
            check("stall_diff",  out_diff, 16'h9999);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release", out_valid, 0);
        check("hold_diff", out_diff, 16'h9999);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("pending_not_taken", seen, 0);

        for (int i = 0; i < 4; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            finish_op();
        end

        run_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0); finish_op();

        // Reset after two slices aborts the operation.
        @(negedge clk);
        in_a = 16'h4321; in_b = 16'h1111; in_bin = 1'b0; in_sat = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_in_ready",  in_ready,  1);
        check("abort_out_valid", out_valid, 0);
        check("abort_diff",      out_diff,  0);
        check("abort_flags",     {out_borrow, out_ovf, out_zero}, 0);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", seen, 0);

        run_op(16'h0010, 16'h0001, 1'b0, 1'b0); finish_op();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
